// File: rtl/tt_mux_ctrl_pkg.sv
// Shared types and default configuration for the TinyTapeout mux control sequencer.
// Optional build macro used by the sequencer: TT_MUX_CTRL_INCREMENTAL_EN.
package tt_mux_ctrl_pkg;

  localparam int DEF_SEL_W        = 8;
  localparam int DEF_NUM_DESIGNS  = 250;
  localparam int DEF_RST_CYCLES   = 4;
  localparam int DEF_PULSE_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_GAP    = 3'd2,
    S_INC_HI = 3'd3,
    S_INC_LO = 3'd4
  } state_t;

endpackage

// File: rtl/tt_mux_ctrl_pulse_gen.sv
// Single increment strobe: PULSE_CYCLES high then PULSE_CYCLES low after start.
// last flags the final low cycle so the caller can chain the next pulse with no gap.
module tt_mux_ctrl_pulse_gen #(
  parameter int PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic inc,
  output logic hi_end,
  output logic last
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);

  logic          hi;
  logic          lo;
  logic [PW-1:0] ph;

  // Phase counter counts remaining cycles of the current half; start wins over everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 1'b0;
      lo <= 1'b0;
      ph <= '0;
    end else if (start) begin
      hi <= 1'b1;
      lo <= 1'b0;
      ph <= PW'(PULSE_CYCLES - 1);
    end else if (hi) begin
      if (ph == '0) begin
        hi <= 1'b0;
        lo <= 1'b1;
        ph <= PW'(PULSE_CYCLES - 1);
      end else begin
        ph <= ph - PW'(1);
      end
    end else if (lo) begin
      if (ph == '0) lo <= 1'b0;
      else          ph <= ph - PW'(1);
    end
  end

  assign inc    = hi;
  assign hi_end = hi && (ph == '0);
  assign last   = lo && (ph == '0);

endmodule

// File: rtl/tt_mux_ctrl_sequencer.sv
// Drives the TinyTapeout design-select mux: chain reset, N increment pulses, re-enable.
// Build macro TT_MUX_CTRL_INCREMENTAL_EN: step forward from the current selection
// instead of resetting the chain when the target is at or above cur_sel.
module tt_mux_ctrl_sequencer
  import tt_mux_ctrl_pkg::*;
#(
  parameter int SEL_W        = DEF_SEL_W,
  parameter int NUM_DESIGNS  = DEF_NUM_DESIGNS,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  output logic             ctrl_sel_rst_n,
  output logic             ctrl_sel_inc,
  output logic             ctrl_ena,
  output logic [SEL_W-1:0] cur_sel,
  output logic             cur_valid,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic [SEL_W-1:0] target;
  logic [SEL_W-1:0] cnt;      // RST cycle count, then pulse count
  logic             pg_start;
  logic             pg_hi_end;
  logic             pg_last;
  logic             oor;
  logic             inc_ok;
  logic             pulses_done;

  assign req_ready   = (state == S_IDLE);
  assign oor         = 32'(req_sel) >= NUM_DESIGNS;
  // cnt holds the chain position minus one while pulsing, so this also covers the incremental base
  assign pulses_done = (cnt + SEL_W'(1)) == target;

`ifdef TT_MUX_CTRL_INCREMENTAL_EN
  assign inc_ok = cur_valid && (req_sel >= cur_sel);
`else
  assign inc_ok = 1'b0;
`endif

  // Kick a new pulse out of GAP, back-to-back between pulses, or directly on an incremental accept
  always_comb begin
    pg_start = 1'b0;
    if (state == S_GAP && target != '0)                            pg_start = 1'b1;
    if (state == S_INC_LO && pg_last && !pulses_done)              pg_start = 1'b1;
    if (state == S_IDLE && req_valid && !oor && inc_ok && req_sel != cur_sel) pg_start = 1'b1;
  end

  tt_mux_ctrl_pulse_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_pulse (
    .clk    (clk),
    .reset  (reset),
    .start  (pg_start),
    .inc    (ctrl_sel_inc),
    .hi_end (pg_hi_end),
    .last   (pg_last)
  );

  // Sequencer FSM and registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      target         <= '0;
      cnt            <= '0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_ena       <= 1'b0;
      cur_sel        <= '0;
      cur_valid      <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          if (oor) begin
            err <= 1'b1;
          end else if (inc_ok) begin
            target <= req_sel;
            if (req_sel == cur_sel) begin
              done <= 1'b1;
            end else begin
              ctrl_ena  <= 1'b0;
              cur_valid <= 1'b0;
              cnt       <= cur_sel;
              state     <= S_INC_HI;
            end
          end else begin
            target         <= req_sel;
            ctrl_ena       <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            cur_valid      <= 1'b0;
            cnt            <= '0;
            state          <= S_RST;
          end
        end
        S_RST: begin
          if (cnt == SEL_W'(RST_CYCLES - 1)) begin
            ctrl_sel_rst_n <= 1'b1;
            state          <= S_GAP;
          end else begin
            cnt <= cnt + SEL_W'(1);
          end
        end
        S_GAP: begin
          cnt <= '0;
          if (target == '0) begin
            state     <= S_IDLE;
            ctrl_ena  <= 1'b1;
            done      <= 1'b1;
            cur_sel   <= target;
            cur_valid <= 1'b1;
          end else begin
            state <= S_INC_HI;
          end
        end
        S_INC_HI: if (pg_hi_end) state <= S_INC_LO;
        S_INC_LO: if (pg_last) begin
          if (pulses_done) begin
            state     <= S_IDLE;
            ctrl_ena  <= 1'b1;
            done      <= 1'b1;
            cur_sel   <= target;
            cur_valid <= 1'b1;
          end else begin
            cnt   <= cnt + SEL_W'(1);
            state <= S_INC_HI;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tt_mux_ctrl_sequencer.md
Name: tt_mux_ctrl_sequencer

Overview:
- Upstream driver for the TinyTapeout design-select mux control interface (ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena).
- Accepts a design index over a valid/ready handshake.
- Generates the select-chain reset, then N increment pulses, then re-enables the selected design.
- Sits between the management-side controller (or testbench) and the mux control pins of user_project_wrapper.

Parameters:
- SEL_W, 8, width of the design index.
- NUM_DESIGNS, 250, number of selectable designs; valid indices are 0..NUM_DESIGNS-1.
- RST_CYCLES, 4, cycles that ctrl_sel_rst_n is held low; must be >= 1.
- PULSE_CYCLES, 2, high time and low time of each ctrl_sel_inc pulse; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  select request valid.
- req_sel  input  SEL_W  requested design index.
- req_ready  output  1  high only in IDLE.
- ctrl_sel_rst_n  output  1  select-chain reset, active low.
- ctrl_sel_inc  output  1  select-chain increment strobe.
- ctrl_ena  output  1  enable for the selected design.
- cur_sel  output  SEL_W  currently selected index.
- cur_valid  output  1  cur_sel is meaningful.
- done  output  1  one-cycle pulse when a selection completes.
- err  output  1  one-cycle pulse when a request is out of range.

Behaviour:
- Reset values (all outputs registered):
  - ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0.
  - cur_sel=0, cur_valid=0, done=0, err=0.
  - State=IDLE, so req_ready=1 once reset is released.
- States: IDLE, RST, GAP, INC_HI, INC_LO.
- IDLE:
  - ctrl_sel_rst_n=1 except immediately after reset (it stays 0 until the first accepted request).
  - ctrl_ena holds its last value.
- Handshake: a request is accepted at edge T when req_valid && req_ready.
  - req_sel is latched as target.
  - Requests while busy are not accepted; req_valid may stay high.
- Out-of-range request (req_sel >= NUM_DESIGNS):
  - Accepted, err=1 at T+1, state stays IDLE.
  - No change to ctrl_*, cur_sel or cur_valid.
- Normal path (N = target):
  - T+1..T+RST_CYCLES: state RST, ctrl_ena=0, ctrl_sel_rst_n=0, cur_valid=0.
  - T+RST_CYCLES+1: state GAP, ctrl_sel_rst_n=1.
  - Pulse k (k=0..N-1) starts at S_k = T+RST_CYCLES+2+2*k*PULSE_CYCLES.
    - ctrl_sel_inc=1 for PULSE_CYCLES cycles (INC_HI), then 0 for PULSE_CYCLES cycles (INC_LO).
  - Completion at E = T+RST_CYCLES+2+2*N*PULSE_CYCLES:
    - ctrl_ena=1, done=1, cur_sel=N, cur_valid=1, state IDLE, req_ready=1.
  - N=0: GAP goes directly to completion, so E=T+RST_CYCLES+2.
- A new request may be accepted at edge E (back-to-back).
- Internal pulse counter is SEL_W bits and phase counter is clog2(PULSE_CYCLES+1) bits. Neither wraps, because the target is range-checked before use.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous); the in-flight request is discarded and no done is produced.
- Simultaneous req_valid with reset: reset wins; no request is accepted.

Optional Feature:
- Macro: TT_MUX_CTRL_INCREMENTAL_EN.
- With macro, when cur_valid=1 and target >= cur_sel:
  - RST and GAP are skipped; D = target - cur_sel.
  - ctrl_ena=0 from T+1.
  - Pulse k starts at T+1+2*k*PULSE_CYCLES.
  - Completion at E = T+1+2*D*PULSE_CYCLES.
  - D=0: ctrl_ena stays 1 and done=1 at T+1.
  - target < cur_sel or cur_valid=0 uses the normal path.
- Without macro: every request uses the normal path.

Decomposition:
- Package tt_mux_ctrl_pkg holds:
  - state enum type.
  - default constants SEL_W/NUM_DESIGNS/RST_CYCLES/PULSE_CYCLES.
- Sub-module tt_mux_ctrl_pulse_gen: generates one PULSE_CYCLES-high/PULSE_CYCLES-low strobe on start and asserts last on the final low cycle. The FSM counts pulses around it.

Test Plan:
- Defaults, reset release, req_sel=3 at T -> ctrl_sel_rst_n low T+1..T+4; inc high at T+6,7 / T+10,11 / T+14,15; ctrl_ena=1, done=1, cur_sel=3 at T+18.
- req_sel=0 -> rst low T+1..T+4, no inc pulses, ctrl_ena=1 and done at T+6.
- req_sel=250 -> err=1 at T+1; ctrl_* and cur_sel unchanged; req_ready stays 1.
- req_valid held high during a sel=3 sequence with a second request sel=5 -> second request accepted exactly at T+18; completes at T+18+26=T+44 with cur_sel=5.
- Assert reset at T+9 of a sel=3 sequence -> ctrl_sel_inc, ctrl_ena, cur_valid=0 and ctrl_sel_rst_n=0 immediately; no done; after release a sel=2 request completes normally.
- With TT_MUX_CTRL_INCREMENTAL_EN, cur_sel=3, request 5 at T -> inc high at T+1,2 and T+5,6; done at T+9. Request 3 at T -> done at T+1 with ctrl_ena held 1. Request 1 -> normal path.
